// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with branch/jump, stall, call/return stack and perf counters
// Ports: clock_i/reset_i (async, active-high); start_i/startadd_i load PC and flush the RAS;
// stall_i freezes all state; ret_i/call_i/jump_i/branchf_i/branchb_i select the redirect,
// target_i is the offset or absolute address; pc_o is the registered PC; ras_empty_o/ras_full_o
// decode the RAS fill level; ras_err_o is the sticky over/underflow flag; icount_o/bcount_o are
// saturating counts of sequential advances and taken redirects.
module pc_sequencer #(
  parameter int AW        = 8,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 15
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [AW-1:0]    startadd_i,
  input  logic             stall_i,
  input  logic             branchf_i,
  input  logic             branchb_i,
  input  logic             jump_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [AW-1:0]    target_i,
  output logic [AW-1:0]    pc_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_err_o,
  output logic [CNT_W-1:0] icount_o,
  output logic [CNT_W-1:0] bcount_o
);
  localparam int SW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [SW-1:0] SP_MAX   = SW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);
  logic [AW-1:0]    r_pc;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_sp;
  logic             r_err;
  logic [CNT_W-1:0] r_icnt;
  logic [CNT_W-1:0] r_bcnt;
  logic [AW-1:0]    r_ras [RAS_DEPTH];
  logic [AW-1:0]    w_pc_n;
  logic [AW-1:0]    w_pc_inc;
  logic [CW-1:0]    w_cnt_n;
  logic [SW-1:0]    w_sp_n;
  logic [SW-1:0]    w_sp_inc;
  logic [SW-1:0]    w_sp_dec;
  logic             w_err_n;
  logic             w_push;
  logic             w_seq;
  logic             w_br;
  logic             w_empty;
  logic             w_full;
  assign w_pc_inc = r_pc + AW'(1);
  // r_sp is the next free slot of a circular buffer, so a push when full
  // silently overwrites the oldest entry
  assign w_sp_inc = (r_sp == SP_MAX) ? '0 : r_sp + SW'(1);
  assign w_sp_dec = (r_sp == '0) ? SP_MAX : r_sp - SW'(1);
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_FULL);
  always_comb begin
    w_pc_n  = r_pc;
    w_cnt_n = r_cnt;
    w_sp_n  = r_sp;
    w_err_n = r_err;
    w_push  = 1'b0;
    w_seq   = 1'b0;
    w_br    = 1'b0;
    if (start_i) begin
      w_pc_n  = startadd_i;
      w_cnt_n = '0;
      w_sp_n  = '0;
      w_err_n = 1'b0;
    end else if (stall_i) begin
      w_pc_n = r_pc;
    end else if (ret_i) begin
      w_pc_n  = w_empty ? w_pc_inc : r_ras[w_sp_dec];
      w_cnt_n = w_empty ? r_cnt : r_cnt - CW'(1);
      w_sp_n  = w_empty ? r_sp : w_sp_dec;
      w_err_n = r_err | w_empty;
      w_seq   = w_empty;
      w_br    = !w_empty;
    end else if (call_i) begin
      w_pc_n  = target_i;
      w_cnt_n = w_full ? r_cnt : r_cnt + CW'(1);
      w_sp_n  = w_sp_inc;
      w_err_n = r_err | w_full;
      w_push  = 1'b1;
      w_br    = 1'b1;
    end else if (jump_i) begin
      w_pc_n = target_i;
      w_br   = 1'b1;
    end else if (branchf_i) begin
      w_pc_n = r_pc + target_i;
      w_br   = 1'b1;
    end else if (branchb_i) begin
      w_pc_n = r_pc - target_i;
      w_br   = 1'b1;
    end else begin
      w_pc_n = w_pc_inc;
      w_seq  = 1'b1;
    end
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_pc   <= '0;
      r_cnt  <= '0;
      r_sp   <= '0;
      r_err  <= 1'b0;
      r_icnt <= '0;
      r_bcnt <= '0;
    end else begin
      r_pc   <= w_pc_n;
      r_cnt  <= w_cnt_n;
      r_sp   <= w_sp_n;
      r_err  <= w_err_n;
      r_icnt <= (w_seq && r_icnt != '1) ? r_icnt + CNT_W'(1) : r_icnt;
      r_bcnt <= (w_br && r_bcnt != '1) ? r_bcnt + CNT_W'(1) : r_bcnt;
    end
  end
  // stack contents need no reset; only the count and pointer define validity
  always_ff @(posedge clock_i) begin
    if (w_push) r_ras[r_sp] <= w_pc_inc;
  end
  assign pc_o        = r_pc;
  assign ras_empty_o = w_empty;
  assign ras_full_o  = w_full;
  assign ras_err_o   = r_err;
  assign icount_o    = r_icnt;
  assign bcount_o    = r_bcnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard-driven bench for pc_sequencer (AW=8, RAS_DEPTH=4, CNT_W=4)
module tb_pc_sequencer;
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] ST = 7'b1000000;
  localparam logic [6:0] SL = 7'b0100000;
  localparam logic [6:0] RT = 7'b0010000;
  localparam logic [6:0] CL = 7'b0001000;
  localparam logic [6:0] JP = 7'b0000100;
  localparam logic [6:0] BF = 7'b0000010;
  localparam logic [6:0] BB = 7'b0000001;
  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] startadd_i = '0;
  logic       stall_i = 1'b0;
  logic       branchf_i = 1'b0;
  logic       branchb_i = 1'b0;
  logic       jump_i = 1'b0;
  logic       call_i = 1'b0;
  logic       ret_i = 1'b0;
  logic [7:0] target_i = '0;
  logic [7:0] pc_o;
  logic       ras_empty_o;
  logic       ras_full_o;
  logic       ras_err_o;
  logic [3:0] icount_o;
  logic [3:0] bcount_o;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  pc_sequencer #(.AW(8), .RAS_DEPTH(4), .CNT_W(4)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .startadd_i(startadd_i),
    .stall_i(stall_i), .branchf_i(branchf_i), .branchb_i(branchb_i), .jump_i(jump_i),
    .call_i(call_i), .ret_i(ret_i), .target_i(target_i), .pc_o(pc_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .ras_err_o(ras_err_o),
    .icount_o(icount_o), .bcount_o(bcount_o)
  );
  always #5 clock_i = ~clock_i;
  task automatic drive(input logic [6:0] c, input logic [7:0] sa, input logic [7:0] t, input logic [7:0] e);
    {start_i, stall_i, ret_i, call_i, jump_i, branchf_i, branchb_i} = c;
    startadd_i = sa;
    target_i = t;
    exp_q.push_back(e);
    @(posedge clock_i);
    #1;
    {start_i, stall_i, ret_i, call_i, jump_i, branchf_i, branchb_i} = NO;
  endtask
  task automatic test_reset();
    logic [7:0] e;
    reset_i = 1'b1;
    repeat (2) @(posedge clock_i);
    #1;
    checks++;
    if ({pc_o, ras_empty_o, ras_full_o, ras_err_o, icount_o, bcount_o} !== {8'h00, 3'b100, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state got pc=%h e=%b f=%b err=%b ic=%h bc=%h", pc_o, ras_empty_o, ras_full_o, ras_err_o, icount_o, bcount_o);
    end
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(NO, 8'h00, 8'h00, 8'(i + 1));
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e) begin errors++; $display("FAIL seq[%0d] pc_o=%h expected %h", i, pc_o, e); end
    end
    checks++;
    if ({icount_o, bcount_o, ras_empty_o} !== {4'd3, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL seq_counts ic=%0d bc=%0d empty=%b expected 3 0 1", icount_o, bcount_o, ras_empty_o);
    end
  endtask
  task automatic test_branch();
    logic [6:0] c[3] = '{ST, BF, BB};
    logic [7:0] s[3] = '{8'hF0, 8'h00, 8'h00};
    logic [7:0] t[3] = '{8'h00, 8'h20, 8'h05};
    logic [7:0] p[3] = '{8'hF0, 8'h10, 8'h0B};
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(c[i], s[i], t[i], p[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e) begin errors++; $display("FAIL branch[%0d] pc_o=%h expected %h", i, pc_o, e); end
    end
    checks++;
    if (bcount_o !== 4'd2) begin errors++; $display("FAIL branch_bcount got %0d expected 2", bcount_o); end
  endtask
  task automatic test_call_ret();
    logic [6:0] c[5] = '{ST, CL, CL, RT, RT};
    logic [7:0] t[5] = '{8'h00, 8'h40, 8'h80, 8'h00, 8'h00};
    logic [7:0] p[5] = '{8'h10, 8'h40, 8'h80, 8'h41, 8'h11};
    logic       m[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(c[i], 8'h10, t[i], p[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, ras_empty_o, ras_full_o} !== {e, m[i], 1'b0}) begin
        errors++;
        $display("FAIL call_ret[%0d] pc=%h empty=%b full=%b expected pc=%h empty=%b full=0", i, pc_o, ras_empty_o, ras_full_o, e, m[i]);
      end
    end
    checks++;
    if (bcount_o !== 4'd6) begin errors++; $display("FAIL call_ret_bcount got %0d expected 6", bcount_o); end
  endtask
  task automatic test_overflow();
    logic [6:0] c[12] = '{ST, CL, CL, CL, CL, CL, RT, RT, RT, RT, RT, ST};
    logic [7:0] t[12] = '{8'h00, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] p[12] = '{8'h00, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h51, 8'h41, 8'h31, 8'h21, 8'h22, 8'h00};
    logic [2:0] f[12] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b010, 3'b011, 3'b001, 3'b001, 3'b001, 3'b101, 3'b101, 3'b100};
    logic [7:0] e;
    for (int i = 0; i < 12; i++) begin
      drive(c[i], 8'h00, t[i], p[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, ras_empty_o, ras_full_o, ras_err_o} !== {e, f[i]}) begin
        errors++;
        $display("FAIL overflow[%0d] pc=%h e/f/err=%b%b%b expected pc=%h e/f/err=%b", i, pc_o, ras_empty_o, ras_full_o, ras_err_o, e, f[i]);
      end
    end
    checks++;
    if ({icount_o, bcount_o} !== {4'd4, 4'd15}) begin
      errors++;
      $display("FAIL overflow_counts ic=%0d bc=%0d expected 4 15", icount_o, bcount_o);
    end
  endtask
  task automatic test_priority();
    logic [6:0] c[7] = '{CL, ST | SL | CL, CL, SL | RT, CL | JP, RT, RT};
    logic [7:0] t[7] = '{8'h50, 8'h99, 8'h70, 8'h00, 8'h90, 8'h00, 8'h00};
    logic [7:0] p[7] = '{8'h50, 8'h33, 8'h70, 8'h70, 8'h90, 8'h71, 8'h34};
    logic       m[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(c[i], 8'h33, t[i], p[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_o, ras_empty_o} !== {e, m[i]}) begin
        errors++;
        $display("FAIL priority[%0d] pc=%h empty=%b expected pc=%h empty=%b", i, pc_o, ras_empty_o, e, m[i]);
      end
    end
    checks++;
    if ({icount_o, bcount_o} !== {4'd4, 4'd15}) begin
      errors++;
      $display("FAIL priority_counts ic=%0d bc=%0d expected 4 15", icount_o, bcount_o);
    end
  endtask
  task automatic test_saturation();
    logic [7:0] e;
    logic [3:0] ic;
    for (int i = 0; i < 20; i++) begin
      drive(NO, 8'h00, 8'h00, 8'(8'h35 + i));
      e = exp_q.pop_front();
      ic = (4 + i + 1 > 15) ? 4'd15 : 4'(4 + i + 1);
      checks++;
      if ({pc_o, icount_o} !== {e, ic}) begin
        errors++;
        $display("FAIL saturate[%0d] pc=%h ic=%0d expected pc=%h ic=%0d", i, pc_o, icount_o, e, ic);
      end
    end
  endtask
  task automatic test_async_reset();
    logic [7:0] e;
    drive(CL, 8'h00, 8'hA0, 8'hA0);
    e = exp_q.pop_front();
    checks++;
    if (pc_o !== e) begin errors++; $display("FAIL pre_reset_call pc_o=%h expected %h", pc_o, e); end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if ({clock_i, pc_o, ras_empty_o, ras_full_o, ras_err_o, icount_o, bcount_o} !== {1'b1, 8'h00, 3'b100, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL async_reset clk=%b pc=%h e=%b f=%b err=%b ic=%h bc=%h", clock_i, pc_o, ras_empty_o, ras_full_o, ras_err_o, icount_o, bcount_o);
    end
    #1 reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    drive(NO, 8'h00, 8'h00, 8'h02);
    e = exp_q.pop_front();
    checks++;
    if ({pc_o, icount_o} !== {e, 4'd2}) begin errors++; $display("FAIL post_reset pc=%h ic=%0d expected %h 2", pc_o, icount_o, e); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_priority();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
